bidir_transceiver: RTL and testbench

BIDIR_TRANSCEIVER -- requirements
Module: bidir_transceiver

---
 rtl/bidir_transceiver.sv | 101 ++++++++++
 tb/tb_bidir_transceiver.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/bidir_transceiver.sv
// Bidirectional bus transceiver: passes A->B or B->A with a dead turnaround between directions.
// Bus paths are combinational; state, snap and flags update one clock after the request.
module bidir_transceiver #(
    parameter int WIDTH       = 8,
    parameter int TURN_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             dir_req,
    inout  wire  [WIDTH-1:0] a_io,
    inout  wire  [WIDTH-1:0] b_io,
    output logic             active,
    output logic             busy,
    output logic             dir_out,
    output logic [WIDTH-1:0] snap
);

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        A2B  = 2'd1,
        B2A  = 2'd2,
        TURN = 2'd3
    } state_t;

    localparam logic [7:0] TURN_LOAD = 8'(TURN_CYCLES);

    state_t           r_state;
    state_t           w_next;
    logic             w_load;
    logic             r_target;     // 1 = B2A is the direction entered after TURN
    logic [7:0]       r_cnt;
    logic             r_dir;
    logic [WIDTH-1:0] r_snap;

    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        case (r_state)
            OFF: begin
                if (en) w_next = dir_req ? B2A : A2B;
            end
            A2B: begin
                if (!en) begin
                    w_next = OFF;
                end else if (dir_req) begin
                    w_next = TURN;
                    w_load = 1'b1;
                end
            end
            B2A: begin
                if (!en) begin
                    w_next = OFF;
                end else if (!dir_req) begin
                    w_next = TURN;
                    w_load = 1'b1;
                end
            end
            TURN: begin
                // dir_req is deliberately ignored here; only en decides between target and OFF
                if (r_cnt <= 8'd1) begin
                    if (!en) w_next = OFF;
                    else     w_next = r_target ? B2A : A2B;
                end
            end
            default: w_next = OFF;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= OFF;
            r_target <= 1'b0;
            r_cnt    <= 8'd0;
            r_dir    <= 1'b0;
            r_snap   <= '0;
        end else begin
            r_state <= w_next;
            if (w_load) begin
                r_target <= (r_state == A2B);
                r_cnt    <= TURN_LOAD;
            end else if (r_state == TURN && r_cnt != 8'd0) begin
                r_cnt <= r_cnt - 8'd1;
            end
            if (w_next == A2B)      r_dir <= 1'b0;
            else if (w_next == B2A) r_dir <= 1'b1;
            if (r_state == A2B)      r_snap <= a_io;
            else if (r_state == B2A) r_snap <= b_io;
        end
    end

    assign active  = (r_state == A2B) || (r_state == B2A);
    assign busy    = (r_state == TURN);
    assign dir_out = r_dir;
    assign snap    = r_snap;

    // Drive enables come only from registered state, so async reset releases both buses at once
    assign b_io = (r_state == A2B) ? a_io : {WIDTH{1'bz}};
    assign a_io = (r_state == B2A) ? b_io : {WIDTH{1'bz}};

endmodule

// File: tb/tb_bidir_transceiver.sv
// Directed bench for bidir_transceiver; pulled-up buses read all-ones when nobody drives them.
module tb_bidir_transceiver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   checks = 0;
    int   errors = 0;

    // 8-bit instance, TURN_CYCLES = 2
    logic       en8, dir8, a8_oe, b8_oe;
    logic [7:0] a8_drv, b8_drv;
    tri1  [7:0] a8, b8;
    wire        active8, busy8, dirout8;
    wire  [7:0] snap8;
    assign a8 = a8_oe ? a8_drv : 8'bz;
    assign b8 = b8_oe ? b8_drv : 8'bz;

    bidir_transceiver #(.WIDTH(8), .TURN_CYCLES(2)) u_dut8 (
        .clk(clk), .rst(rst), .en(en8), .dir_req(dir8), .a_io(a8), .b_io(b8),
        .active(active8), .busy(busy8), .dir_out(dirout8), .snap(snap8)
    );

    // 1-bit instance, TURN_CYCLES = 1
    logic en1, dir1, a1_oe, b1_oe, a1_drv, b1_drv;
    tri1  a1, b1;
    wire  active1, busy1, dirout1, snap1;
    assign a1 = a1_oe ? a1_drv : 1'bz;
    assign b1 = b1_oe ? b1_drv : 1'bz;

    bidir_transceiver #(.WIDTH(1), .TURN_CYCLES(1)) u_dut1 (
        .clk(clk), .rst(rst), .en(en1), .dir_req(dir1), .a_io(a1), .b_io(b1),
        .active(active1), .busy(busy1), .dir_out(dirout1), .snap(snap1)
    );

    // 16-bit instance, TURN_CYCLES = 5
    logic        en16, dir16, a16_oe, b16_oe;
    logic [15:0] a16_drv, b16_drv;
    tri1  [15:0] a16, b16;
    wire         active16, busy16, dirout16;
    wire  [15:0] snap16;
    assign a16 = a16_oe ? a16_drv : 16'bz;
    assign b16 = b16_oe ? b16_drv : 16'bz;

    bidir_transceiver #(.WIDTH(16), .TURN_CYCLES(5)) u_dut16 (
        .clk(clk), .rst(rst), .en(en16), .dir_req(dir16), .a_io(a16), .b_io(b16),
        .active(active16), .busy(busy16), .dir_out(dirout16), .snap(snap16)
    );

    task automatic test_reset;
        rst = 1'b1;
        en8 = 1'b0; dir8 = 1'b0; a8_oe = 1'b0; b8_oe = 1'b0; a8_drv = 8'h00; b8_drv = 8'h00;
        en1 = 1'b0; dir1 = 1'b0; a1_oe = 1'b0; b1_oe = 1'b0; a1_drv = 1'b0; b1_drv = 1'b0;
        en16 = 1'b0; dir16 = 1'b0; a16_oe = 1'b0; b16_oe = 1'b0; a16_drv = '0; b16_drv = '0;
        repeat (2) @(posedge clk);
        #2;
        checks++; if (active8 !== 1'b0) begin errors++; $display("FAIL reset_active: got %b expected 0", active8); end
        checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy8); end
        checks++; if (dirout8 !== 1'b0) begin errors++; $display("FAIL reset_dir_out: got %b expected 0", dirout8); end
        checks++; if (snap8 !== 8'h00) begin errors++; $display("FAIL reset_snap: got %h expected 00", snap8); end
        checks++; if (a8 !== 8'hFF || b8 !== 8'hFF) begin errors++; $display("FAIL reset_buses_z: got a=%h b=%h expected FF FF", a8, b8); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_a2b;
        a8_drv = 8'hA5; a8_oe = 1'b1; en8 = 1'b1; dir8 = 1'b0;
        @(posedge clk); #2;
        checks++; if (b8 !== 8'hA5) begin errors++; $display("FAIL a2b_b_drive: got %h expected A5", b8); end
        checks++; if (active8 !== 1'b1 || busy8 !== 1'b0) begin errors++; $display("FAIL a2b_flags: got active=%b busy=%b expected 1 0", active8, busy8); end
        checks++; if (dirout8 !== 1'b0) begin errors++; $display("FAIL a2b_dir_out: got %b expected 0", dirout8); end
        checks++; if (snap8 !== 8'h00) begin errors++; $display("FAIL a2b_snap_early: got %h expected 00", snap8); end
        @(posedge clk); #2;
        checks++; if (snap8 !== 8'hA5) begin errors++; $display("FAIL a2b_snap: got %h expected A5", snap8); end
        a8_drv = 8'h5A; #1;
        checks++; if (b8 !== 8'h5A) begin errors++; $display("FAIL a2b_comb_path: got %h expected 5A", b8); end
        @(posedge clk); #2;
        checks++; if (snap8 !== 8'h5A || active8 !== 1'b1) begin errors++; $display("FAIL a2b_same_dir_hold: got snap=%h active=%b expected 5A 1", snap8, active8); end
    endtask

    task automatic test_turnaround;
        dir8 = 1'b1;
        @(posedge clk); #1; a8_oe = 1'b0; #1;
        checks++; if (busy8 !== 1'b1 || active8 !== 1'b0) begin errors++; $display("FAIL turn1_flags: got busy=%b active=%b expected 1 0", busy8, active8); end
        checks++; if (a8 !== 8'hFF || b8 !== 8'hFF) begin errors++; $display("FAIL turn1_buses_z: got a=%h b=%h expected FF FF", a8, b8); end
        checks++; if (dirout8 !== 1'b0) begin errors++; $display("FAIL turn1_dir_hold: got %b expected 0", dirout8); end
        @(posedge clk); #2;
        checks++; if (busy8 !== 1'b1 || b8 !== 8'hFF || a8 !== 8'hFF) begin errors++; $display("FAIL turn2: got busy=%b a=%h b=%h expected 1 FF FF", busy8, a8, b8); end
        b8_drv = 8'h3C; b8_oe = 1'b1;
        @(posedge clk); #2;
        checks++; if (busy8 !== 1'b0 || active8 !== 1'b1) begin errors++; $display("FAIL b2a_flags: got busy=%b active=%b expected 0 1", busy8, active8); end
        checks++; if (a8 !== 8'h3C) begin errors++; $display("FAIL b2a_a_drive: got %h expected 3C", a8); end
        checks++; if (dirout8 !== 1'b1) begin errors++; $display("FAIL b2a_dir_out: got %b expected 1", dirout8); end
        checks++; if (snap8 !== 8'h5A) begin errors++; $display("FAIL b2a_snap_hold: got %h expected 5A", snap8); end
        @(posedge clk); #2;
        checks++; if (snap8 !== 8'h3C) begin errors++; $display("FAIL b2a_snap: got %h expected 3C", snap8); end
    endtask

    task automatic test_turn_disable;
        dir8 = 1'b0;
        @(posedge clk); #1; b8_oe = 1'b0; en8 = 1'b0; #1;
        checks++; if (busy8 !== 1'b1) begin errors++; $display("FAIL dis_turn1: got busy=%b expected 1", busy8); end
        @(posedge clk); #2;
        checks++; if (busy8 !== 1'b1) begin errors++; $display("FAIL dis_turn2_no_abort: got busy=%b expected 1", busy8); end
        @(posedge clk); #2;
        checks++; if (busy8 !== 1'b0 || active8 !== 1'b0) begin errors++; $display("FAIL dis_off_flags: got busy=%b active=%b expected 0 0", busy8, active8); end
        checks++; if (dirout8 !== 1'b1 || snap8 !== 8'h3C) begin errors++; $display("FAIL dis_off_hold: got dir=%b snap=%h expected 1 3C", dirout8, snap8); end
        checks++; if (a8 !== 8'hFF || b8 !== 8'hFF) begin errors++; $display("FAIL dis_off_buses_z: got a=%h b=%h expected FF FF", a8, b8); end
    endtask

    task automatic test_disable_priority;
        b8_drv = 8'h96; b8_oe = 1'b1; en8 = 1'b1; dir8 = 1'b1;
        @(posedge clk); #2;
        checks++; if (busy8 !== 1'b0 || active8 !== 1'b1 || a8 !== 8'h96) begin errors++; $display("FAIL off_to_b2a: got busy=%b active=%b a=%h expected 0 1 96", busy8, active8, a8); end
        en8 = 1'b0; dir8 = 1'b0;
        @(posedge clk); #2;
        checks++; if (busy8 !== 1'b0 || active8 !== 1'b0 || a8 !== 8'hFF) begin errors++; $display("FAIL en_priority: got busy=%b active=%b a=%h expected 0 0 FF", busy8, active8, a8); end
    endtask

    task automatic test_async_reset;
        b8_drv = 8'hC3; en8 = 1'b1; dir8 = 1'b1;
        @(posedge clk); #2;
        checks++; if (a8 !== 8'hC3) begin errors++; $display("FAIL pre_rst_b2a: got a=%h expected C3", a8); end
        @(posedge clk);
        @(negedge clk); #1;
        rst = 1'b1; #1;
        checks++; if (a8 !== 8'hFF) begin errors++; $display("FAIL async_rst_a_z: got %h expected FF", a8); end
        checks++; if (active8 !== 1'b0 || busy8 !== 1'b0 || dirout8 !== 1'b0 || snap8 !== 8'h00) begin
            errors++; $display("FAIL async_rst_outputs: got active=%b busy=%b dir=%b snap=%h expected 0 0 0 00", active8, busy8, dirout8, snap8); end
    endtask

    task automatic test_reset_mid_turn;
        b8_oe = 1'b0; a8_drv = 8'h77; a8_oe = 1'b1; en8 = 1'b1; dir8 = 1'b0;
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #2;
        checks++; if (active8 !== 1'b1 || b8 !== 8'h77) begin errors++; $display("FAIL rst_first_edge: got active=%b b=%h expected 1 77", active8, b8); end
        dir8 = 1'b1;
        @(posedge clk); #2;
        checks++; if (busy8 !== 1'b1) begin errors++; $display("FAIL rst_turn_entry: got busy=%b expected 1", busy8); end
        @(negedge clk); rst = 1'b1; #1;
        checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL rst_mid_turn: got busy=%b expected 0", busy8); end
        dir8 = 1'b0;
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #2;
        checks++; if (active8 !== 1'b1 || busy8 !== 1'b0 || dirout8 !== 1'b0 || b8 !== 8'h77) begin
            errors++; $display("FAIL rst_target_discard: got active=%b busy=%b dir=%b b=%h expected 1 0 0 77", active8, busy8, dirout8, b8); end
        en8 = 1'b0;
        @(posedge clk);
    endtask

    task automatic test_sweep_w1;
        int n;
        a1_drv = 1'b0; a1_oe = 1'b1; en1 = 1'b1; dir1 = 1'b0;
        @(posedge clk); #2;
        checks++; if (b1 !== 1'b0 || active1 !== 1'b1) begin errors++; $display("FAIL w1_a2b: got b=%b active=%b expected 0 1", b1, active1); end
        dir1 = 1'b1;
        @(posedge clk); #1; a1_oe = 1'b0; #1;
        n = 0;
        while (busy1 === 1'b1 && n < 20) begin
            n++;
            checks++; if (a1 !== 1'b1 || b1 !== 1'b1) begin errors++; $display("FAIL w1_turn_z: cycle %0d got a=%b b=%b expected 1 1", n, a1, b1); end
            if (n == 1) begin b1_drv = 1'b0; b1_oe = 1'b1; end
            @(posedge clk); #2;
        end
        checks++; if (n != 1) begin errors++; $display("FAIL w1_turn_len: got %0d expected 1", n); end
        checks++; if (active1 !== 1'b1 || dirout1 !== 1'b1 || a1 !== 1'b0) begin errors++; $display("FAIL w1_b2a: got active=%b dir=%b a=%b expected 1 1 0", active1, dirout1, a1); end
        en1 = 1'b0;
        @(posedge clk);
    endtask

    task automatic test_sweep_w16;
        int n;
        a16_drv = 16'h0F0F; a16_oe = 1'b1; en16 = 1'b1; dir16 = 1'b0;
        @(posedge clk); #2;
        checks++; if (b16 !== 16'h0F0F || active16 !== 1'b1) begin errors++; $display("FAIL w16_a2b: got b=%h active=%b expected 0F0F 1", b16, active16); end
        dir16 = 1'b1;
        @(posedge clk); #1; a16_oe = 1'b0; #1;
        n = 0;
        while (busy16 === 1'b1 && n < 20) begin
            n++;
            checks++; if (a16 !== 16'hFFFF || b16 !== 16'hFFFF) begin errors++; $display("FAIL w16_turn_z: cycle %0d got a=%h b=%h expected FFFF FFFF", n, a16, b16); end
            if (n == 5) begin b16_drv = 16'h1234; b16_oe = 1'b1; end
            dir16 = ~dir16;
            @(posedge clk); #2;
        end
        checks++; if (n != 5) begin errors++; $display("FAIL w16_turn_len: got %0d expected 5", n); end
        checks++; if (active16 !== 1'b1 || dirout16 !== 1'b1 || a16 !== 16'h1234) begin
            errors++; $display("FAIL w16_toggle_target: got active=%b dir=%b a=%h expected 1 1 1234", active16, dirout16, a16); end
        @(posedge clk); #2;
        checks++; if (busy16 !== 1'b1) begin errors++; $display("FAIL w16_reeval_after_turn: got busy=%b expected 1", busy16); end
        b16_oe = 1'b0; en16 = 1'b0;
        @(posedge clk);
    endtask

    initial begin
        test_reset();
        test_a2b();
        test_turnaround();
        test_turn_disable();
        test_disable_priority();
        test_async_reset();
        test_reset_mid_turn();
        test_sweep_w1();
        test_sweep_w16();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
